// File: rtl/cache_fill_controller.sv
// Miss fill engine: picks a victim way, writes back a dirty victim, fetches the line and fills the set.
// Build with `define PLRU_EN for per-set tree pseudo-LRU; otherwise a global round-robin counter is used.
module cache_fill_controller #(
  parameter int ways      = 8,
  parameter int tagBits   = 10,
  parameter int indexBits = 6,
  parameter int dataBits  = 9
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          missValid,
  output logic                          missReady,
  input  logic [tagBits-1:0]            missTag,
  input  logic [indexBits-1:0]          missIndex,
  input  logic [ways-1:0]               setValid,
  input  logic [ways-1:0]               setDirty,
  input  logic [tagBits*ways-1:0]       setTags,
  input  logic [dataBits*ways-1:0]      setData,
  input  logic                          hitValid,
  input  logic [indexBits-1:0]          hitIndex,
  input  logic [$clog2(ways)-1:0]       hitWay,
  output logic                          wbValid,
  input  logic                          wbReady,
  output logic [tagBits+indexBits-1:0]  wbAddr,
  output logic [dataBits-1:0]           wbData,
  output logic                          memReqValid,
  input  logic                          memReqReady,
  output logic [tagBits+indexBits-1:0]  memReqAddr,
  input  logic                          memRespValid,
  input  logic [dataBits-1:0]           memRespData,
  output logic                          arrayWe,
  output logic [indexBits-1:0]          arrayIndex,
  output logic [$clog2(ways)-1:0]       arrayWay,
  output logic [tagBits-1:0]            arrayTag,
  output logic [dataBits-1:0]           arrayData,
  output logic                          fillDone
);

  localparam int wayBits = $clog2(ways);
  localparam int sets    = 2 ** indexBits;

  typedef enum logic [2:0] {
    IDLE, SELECT, WRITEBACK, REQUEST, WAIT_RESP, WRITE, DONE
  } stateT;

  stateT                         r_state;
  logic [tagBits-1:0]            r_tag;
  logic [indexBits-1:0]          r_index;
  logic [ways-1:0]               r_setValid;
  logic [ways-1:0]               r_setDirty;
  logic [tagBits-1:0]            r_tagArr  [ways];
  logic [dataBits-1:0]           r_dataArr [ways];
  logic [wayBits-1:0]            r_victim;
  logic                          r_missReady;
  logic                          r_wbValid;
  logic [tagBits+indexBits-1:0]  r_wbAddr;
  logic [dataBits-1:0]           r_wbData;
  logic                          r_memReqValid;
  logic [tagBits+indexBits-1:0]  r_memReqAddr;
  logic                          r_arrayWe;
  logic [indexBits-1:0]          r_arrayIndex;
  logic [wayBits-1:0]            r_arrayWay;
  logic [tagBits-1:0]            r_arrayTag;
  logic [dataBits-1:0]           r_arrayData;
  logic                          r_fillDone;

  logic                          w_freeFound;
  logic [wayBits-1:0]            w_freeWay;
  logic [wayBits-1:0]            w_policyWay;
  logic [wayBits-1:0]            w_victim;
  logic                          w_victimDirty;

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    w_freeFound = 1'b0;
    w_freeWay   = '0;
    for (int w = ways - 1; w >= 0; w--) begin
      if (!r_setValid[w]) begin
        w_freeFound = 1'b1;
        w_freeWay   = wayBits'(w);
      end
    end
  end

  assign w_victim      = w_freeFound ? w_freeWay : w_policyWay;
  assign w_victimDirty = r_setValid[w_victim] & r_setDirty[w_victim];

`ifdef PLRU_EN
  // Heap-ordered tree, root at bit 0; a node bit of 1 steers the victim search right.
  logic [ways-2:0] r_plru [sets];
  logic [ways-2:0] w_hitTree;
  logic [ways-2:0] w_fillBase;
  logic [ways-2:0] w_fillTree;

  function automatic logic [wayBits-1:0] plruVictim(input logic [ways-2:0] tree);
    logic [wayBits-1:0] node;
    logic [wayBits-1:0] way;
    node = '0;
    way  = '0;
    for (int lvl = 0; lvl < wayBits; lvl++) begin
      way[wayBits-1-lvl] = tree[node];
      node = (node << 1) + wayBits'(1) + wayBits'(tree[node]);
    end
    return way;
  endfunction

  function automatic logic [ways-2:0] plruTouch(input logic [ways-2:0] tree,
                                                input logic [wayBits-1:0] way);
    logic [ways-2:0]    next;
    logic [wayBits-1:0] node;
    logic               dir;
    next = tree;
    node = '0;
    for (int lvl = 0; lvl < wayBits; lvl++) begin
      dir        = way[wayBits-1-lvl];
      next[node] = ~dir;
      node       = (node << 1) + wayBits'(1) + wayBits'(dir);
    end
    return next;
  endfunction

  // A same-cycle hit to the fill's set is folded in before the fill's own touch.
  always_comb begin
    w_hitTree  = plruTouch(r_plru[hitIndex], hitWay);
    w_fillBase = (hitValid && (hitIndex == r_index)) ? w_hitTree : r_plru[r_index];
    w_fillTree = plruTouch(w_fillBase, r_victim);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int s = 0; s < sets; s++) r_plru[s] <= '0;
    end else begin
      if (hitValid) r_plru[hitIndex] <= w_hitTree;
      if (r_state == WRITE) r_plru[r_index] <= w_fillTree;
    end
  end

  assign w_policyWay = plruVictim(r_plru[r_index]);
`else
  logic [wayBits-1:0] r_rrCount;
  logic               w_unusedHit;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_rrCount <= '0;
    else if (r_state == WRITE) r_rrCount <= r_rrCount + 1'b1;
  end

  assign w_policyWay = r_rrCount;
  assign w_unusedHit = ^{hitValid, hitIndex, hitWay};
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state       <= IDLE;
      r_tag         <= '0;
      r_index       <= '0;
      r_setValid    <= '0;
      r_setDirty    <= '0;
      r_victim      <= '0;
      r_missReady   <= 1'b1;
      r_wbValid     <= 1'b0;
      r_wbAddr      <= '0;
      r_wbData      <= '0;
      r_memReqValid <= 1'b0;
      r_memReqAddr  <= '0;
      r_arrayWe     <= 1'b0;
      r_arrayIndex  <= '0;
      r_arrayWay    <= '0;
      r_arrayTag    <= '0;
      r_arrayData   <= '0;
      r_fillDone    <= 1'b0;
      for (int w = 0; w < ways; w++) begin
        r_tagArr[w]  <= '0;
        r_dataArr[w] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (missValid) begin
            r_tag       <= missTag;
            r_index     <= missIndex;
            r_setValid  <= setValid;
            r_setDirty  <= setDirty;
            for (int w = 0; w < ways; w++) begin
              r_tagArr[w]  <= setTags[w*tagBits +: tagBits];
              r_dataArr[w] <= setData[w*dataBits +: dataBits];
            end
            r_missReady <= 1'b0;
            r_state     <= SELECT;
          end
        end
        SELECT: begin
          r_victim <= w_victim;
          if (w_victimDirty) begin
            r_wbValid <= 1'b1;
            r_wbAddr  <= {r_tagArr[w_victim], r_index};
            r_wbData  <= r_dataArr[w_victim];
            r_state   <= WRITEBACK;
          end else begin
            r_memReqValid <= 1'b1;
            r_memReqAddr  <= {r_tag, r_index};
            r_state       <= REQUEST;
          end
        end
        WRITEBACK: begin
          if (wbReady) begin
            r_wbValid     <= 1'b0;
            r_memReqValid <= 1'b1;
            r_memReqAddr  <= {r_tag, r_index};
            r_state       <= REQUEST;
          end
        end
        REQUEST: begin
          if (memReqReady) begin
            r_memReqValid <= 1'b0;
            r_state       <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (memRespValid) begin
            r_arrayWe    <= 1'b1;
            r_arrayIndex <= r_index;
            r_arrayWay   <= r_victim;
            r_arrayTag   <= r_tag;
            r_arrayData  <= memRespData;
            r_state      <= WRITE;
          end
        end
        WRITE: begin
          r_arrayWe  <= 1'b0;
          r_fillDone <= 1'b1;
          r_state    <= DONE;
        end
        DONE: begin
          r_fillDone  <= 1'b0;
          r_missReady <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign missReady   = r_missReady;
  assign wbValid     = r_wbValid;
  assign wbAddr      = r_wbAddr;
  assign wbData      = r_wbData;
  assign memReqValid = r_memReqValid;
  assign memReqAddr  = r_memReqAddr;
  assign arrayWe     = r_arrayWe;
  assign arrayIndex  = r_arrayIndex;
  assign arrayWay    = r_arrayWay;
  assign arrayTag    = r_arrayTag;
  assign arrayData   = r_arrayData;
  assign fillDone    = r_fillDone;

endmodule
